pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
- Splits an N-bit operation into STAGES register-separated slices. Each slice computes its groups' sum and passes its carry to the next slice.
- Valid/ready handshake on both sides, so it sits directly in the ALU/datapath streaming path.
- Reports carry, signed overflow and zero for each result.

---
 rtl/pipelined_cla_adder.sv | 250 +++++++++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// pipelined_cla_adder
// ----------------------------------------------------------------------------
// Purpose:
//   Parametrised, pipelined carry-lookahead adder/subtractor. The N-bit
//   operation is split into STAGES register-separated slices of W = N/STAGES
//   bits. Each slice is built from GROUP-bit lookahead groups that are chained
//   by group generate/propagate carries. Each slice hands its carry-out to the
//   next slice through a pipeline register. Results carry carry-out, signed
//   overflow and zero flags.
//
//   N must be a multiple of GROUP*STAGES. STAGES = 1 gives a single
//   registered full-width adder. Latency is STAGES registers, and a new beat
//   can be accepted every cycle.
//
// Optional feature:
//   `define PIPELINED_CLA_SATURATE_EN  -> on signed overflow, out_sum is
//   clamped to the most positive or most negative value. The clamp direction
//   follows the sign of A. out_of and out_cout are reported unchanged.
//   When the macro is undefined, out_sum is the wrapped N-bit result.
//
// Ports:
//   clk        in   1  clock, all state changes on the rising edge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  operand beat valid
//   in_ready   out  1  block can accept a beat this cycle
//   in_a       in   N  operand A
//   in_b       in   N  operand B
//   in_cin     in   1  carry-in (add) / borrow-in (sub)
//   in_sub     in   1  0 = add, 1 = subtract
//   out_valid  out  1  result beat valid
//   out_ready  in   1  downstream accepts result
//   out_sum    out  N  result
//   out_cout   out  1  carry out of MSB (for sub, 1 = no borrow)
//   out_of     out  1  signed two's-complement overflow
//   out_zero   out  1  out_sum == 0
// ============================================================================
module pipelined_cla_adder #(
    parameter int N      = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         out_of,
    output logic         out_zero
);

    localparam int W   = N / STAGES;
    localparam int GPS = W / GROUP;

    // Lookahead carry into bit idx of one group.
    // It is written as the flat sum-of-products form:
    //   c[idx] = OR_j<idx ( g[j] & p[j+1..idx-1] ) | ( cin & p[0..idx-1] )
    // This keeps each carry two logic levels deep instead of rippling.
    // idx == GROUP with cin = 0 gives the group generate term.
    function automatic logic la_carry(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             cin,
        input int               idx
    );
        logic c;
        logic t;
        c = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            if (j < idx) begin
                t = g[j];
                for (int m = 0; m < GROUP; m++) begin
                    if (m > j && m < idx) begin
                        t = t & p[m];
                    end
                end
                c = c | t;
            end
        end
        t = cin;
        for (int m = 0; m < GROUP; m++) begin
            if (m < idx) begin
                t = t & p[m];
            end
        end
        return c | t;
    endfunction

    // One W-bit slice made of GPS lookahead groups.
    // The carry between groups comes from the group terms G | (P & c).
    // It does not come from the last bit's carry, so the group sums
    // never wait on a bit-level ripple.
    // The result is returned as {carry_out, sum}.
    function automatic logic [W:0] cla_slice(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         cin
    );
        logic [W-1:0]     s;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic             c;
        s = '0;
        c = cin;
        for (int gi = 0; gi < GPS; gi++) begin
            p = a[gi*GROUP +: GROUP] ^ b[gi*GROUP +: GROUP];
            g = a[gi*GROUP +: GROUP] & b[gi*GROUP +: GROUP];
            for (int i = 0; i < GROUP; i++) begin
                s[gi*GROUP + i] = p[i] ^ la_carry(p, g, c, i);
            end
            c = la_carry(p, g, 1'b0, GROUP) | ((&p) & c);
        end
        return {c, s};
    endfunction

    // Global advance: the whole pipeline moves together.
    // It moves whenever the output slot is empty or is being drained.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Inter-slice links. Element k is what slice k consumes.
    // Element 0 comes straight from the input port. Element k > 0 is the
    // register written by slice k-1.
    //
    // Operand A and the finished sum bits share one N-bit word that rotates
    // right by W per slice. The low W bits are always the next A bits to
    // consume. Each slice's W sum bits enter at the top. After the last
    // slice, the word holds the complete sum in natural order.
    //
    // Effective B shifts the same way, with zeros filling in from the top.
    logic [N-1:0] link_a [STAGES];
    logic [N-1:0] link_b [STAGES];
    logic         link_c [STAGES];
    logic         link_v [STAGES];

    // Subtraction is folded in here. B is inverted and the carry-in becomes
    // ~borrow, so every slice downstream is a plain adder.
    assign link_a[0] = in_a;
    assign link_b[0] = in_sub ? ~in_b : in_b;
    assign link_c[0] = in_sub ? ~in_cin : in_cin;
    assign link_v[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice

        logic [W-1:0] slice_sum;
        logic         slice_cout;

        assign {slice_cout, slice_sum} = cla_slice(link_a[k][W-1:0], link_b[k][W-1:0], link_c[k]);

        if (k < STAGES - 1) begin : g_mid

            logic [N-1:0] a_q;
            logic [N-1:0] b_q;
            logic         c_q;
            logic         v_q;

            // Slice register.
            // The rotation drops the consumed A/B bits and parks this
            // slice's sum bits at the top of the word. The valid bit travels
            // with the data, so bubbles stay in place rather than collapsing.
            // Nothing moves while the output is stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    v_q <= link_v[k];
                    a_q <= N'({slice_sum, link_a[k]} >> W);
                    b_q <= N'({{W{1'b0}}, link_b[k]} >> W);
                    c_q <= slice_cout;
                end
            end

            assign link_a[k+1] = a_q;
            assign link_b[k+1] = b_q;
            assign link_c[k+1] = c_q;
            assign link_v[k+1] = v_q;

        end else begin : g_last

            logic [N-1:0] wrap_sum;
            logic [N-1:0] final_sum;
            logic         a_msb;
            logic         b_msb;
            logic         ovf;

            logic [N-1:0] sum_q;
            logic         cout_q;
            logic         of_q;
            logic         zero_q;
            logic         v_q;

            // The low W bits of the link words are still the top slice of
            // A and effective B. Their MSBs are the operand sign bits used
            // for overflow detection.
            assign wrap_sum = N'({slice_sum, link_a[k]} >> W);
            assign a_msb    = link_a[k][W-1];
            assign b_msb    = link_b[k][W-1];
            assign ovf      = (a_msb == b_msb) && (slice_sum[W-1] != a_msb);

`ifdef PIPELINED_CLA_SATURATE_EN
            // On overflow the true result lies beyond the side A's sign
            // points to. Clamp to that extreme.
            assign final_sum = ovf ? (a_msb ? {1'b1, {(N-1){1'b0}}}
                                            : {1'b0, {(N-1){1'b1}}})
                                   : wrap_sum;
`else
            assign final_sum = wrap_sum;
`endif

            // Output register.
            // The zero flag is taken from the value actually presented, so
            // it agrees with out_sum even when the sum is clamped.
            // The register holds while out_valid && !out_ready.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q    <= 1'b0;
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    of_q   <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    v_q    <= link_v[k];
                    sum_q  <= final_sum;
                    cout_q <= slice_cout;
                    of_q   <= ovf;
                    zero_q <= (final_sum == '0);
                end
            end

            assign out_valid = v_q;
            assign out_sum   = sum_q;
            assign out_cout  = cout_q;
            assign out_of    = of_q;
            assign out_zero  = zero_q;

        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ============================================================================
// tb_pipelined_cla_adder
// ----------------------------------------------------------------------------
// Directed bench for pipelined_cla_adder with N = 32 and STAGES = 4.
//
// It covers:
//   - reset state
//   - single beats with hand-computed results and latency
//   - slice-boundary carry propagation
//   - subtraction and overflow
//   - back-to-back streaming with an output stall
//   - reset with beats in flight
//   - a long randomly throttled stream checked against a reference model
// ============================================================================
module tb_pipelined_cla_adder;

    localparam int N      = 32;
    localparam int STAGES = 4;
    localparam int LAT    = STAGES - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         out_of;
    logic         out_zero;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         of;
        logic         zero;
    } result_t;

    result_t expQ[$];
    int      nChecks  = 0;
    int      nErrors  = 0;
    int      nRetired = 0;

    pipelined_cla_adder #(
        .N      (N),
        .GROUP  (4),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_of    (out_of),
        .out_zero  (out_zero)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive all source/sink-side inputs in one go
    task automatic applyStimulus(input logic valid, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sub, input logic ready);
        in_valid  = valid;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = ready;
    endtask

    // Independent arithmetic reference using the native + operator
    function automatic result_t refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin, input logic sub);
        logic [N-1:0] bEff;
        logic         cEff;
        logic [N:0]   raw;
        result_t      r;
        bEff   = sub ? ~b : b;
        cEff   = sub ? ~cin : cin;
        raw    = {1'b0, a} + {1'b0, bEff} + {{N{1'b0}}, cEff};
        r.sum  = raw[N-1:0];
        r.cout = raw[N];
        r.of   = (a[N-1] == bEff[N-1]) && (raw[N-1] != a[N-1]);
`ifdef PIPELINED_CLA_SATURATE_EN
        if (r.of) r.sum = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
        r.zero = (r.sum == '0);
        return r;
    endfunction

    // One clock of streaming traffic.
    // The task is entered and left just after a rising edge. Outputs are
    // sampled at the falling edge. A valid output is compared against the
    // head of the expected queue, including on every stalled cycle, so a
    // held output must stay equal to the model value.
    task automatic runCycle(input logic valid, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic cin, input logic sub, input logic ready,
                            output logic accepted, output logic readySeen);
        applyStimulus(valid, a, b, cin, sub, ready);
        @(negedge clk);
        readySeen = in_ready;
        accepted  = valid && in_ready;
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_beat", N'(out_valid), '0);
            end else begin
                checkOutput("stream_sum",  out_sum,        expQ[0].sum);
                checkOutput("stream_cout", N'(out_cout),   N'(expQ[0].cout));
                checkOutput("stream_of",   N'(out_of),     N'(expQ[0].of));
                checkOutput("stream_zero", N'(out_zero),   N'(expQ[0].zero));
                if (out_ready) begin
                    void'(expQ.pop_front());
                    nRetired++;
                end
            end
        end
        if (accepted) expQ.push_back(refModel(a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    // One isolated beat into an empty pipeline with out_ready high.
    // It checks the latency from the acceptance edge and the hand-computed
    // result fields.
    task automatic runSingle(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic cin, input logic sub, input logic [N-1:0] expSum,
                             input logic expCout, input logic expOf, input logic expZero);
        int lat;
        applyStimulus(1'b1, a, b, cin, sub, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, N'(in_ready), N'(1));
        @(posedge clk);
        #1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, N'(lat),      N'(LAT));
        checkOutput({tag, "_sum"},     out_sum,      expSum);
        checkOutput({tag, "_cout"},    N'(out_cout), N'(expCout));
        checkOutput({tag, "_of"},      N'(out_of),   N'(expOf));
        checkOutput({tag, "_zero"},    N'(out_zero), N'(expZero));
        @(posedge clk);
        #1;
    endtask

    logic         got;
    logic         rdy;
    logic         pend;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;
    logic         rs;
    int           accCount;
    int           cycCount;

    initial begin
        $display("[TB] starting pipelined_cla_adder bench");

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", N'(out_valid), '0);
        checkOutput("rst_out_sum",   out_sum,       '0);
        checkOutput("rst_out_cout",  N'(out_cout),  '0);
        checkOutput("rst_out_of",    N'(out_of),    '0);
        checkOutput("rst_out_zero",  N'(out_zero),  '0);
        checkOutput("rst_in_ready",  N'(in_ready),  N'(1));
        @(posedge clk);
        #1;

        // Directed single beats with hand-computed results
`ifdef PIPELINED_CLA_SATURATE_EN
        runSingle("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
        runSingle("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif
        runSingle("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        runSingle("add_slice", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        runSingle("add_cin",   32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        runSingle("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        runSingle("sub_borrow",32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
`ifdef PIPELINED_CLA_SATURATE_EN
        runSingle("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        runSingle("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif

        // Eight back-to-back beats, then a three-cycle output stall while a
        // ninth beat waits at the input
        nRetired = 0;
        for (int i = 0; i < 8; i++) begin
            runCycle(1'b1, 32'h1111_1111 * (i + 1), 32'h0F0F_0F0F ^ N'(i * 32'h0101_0101),
                     1'(i % 2), 1'(i % 3 == 0), 1'b1, got, rdy);
            checkOutput("stream_accept", N'(got), N'(1));
        end
        for (int i = 0; i < 3; i++) begin
            runCycle(1'b1, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1, 1'b0, got, rdy);
            checkOutput("stall_in_ready", N'(rdy), '0);
            checkOutput("stall_no_accept", N'(got), '0);
        end
        runCycle(1'b1, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1, 1'b1, got, rdy);
        checkOutput("resume_accept", N'(got), N'(1));
        for (int i = 0; i < 12; i++) begin
            runCycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, got, rdy);
        end
        checkOutput("stream_retired", N'(nRetired), N'(9));
        checkOutput("stream_drained", N'(expQ.size()), '0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0000_1000 + N'(i), 32'h0000_0100, 1'b0, 1'b0, 1'b1);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", N'(out_valid), '0);
        checkOutput("midrst_out_sum",   out_sum,       '0);
        checkOutput("midrst_in_ready",  N'(in_ready),  N'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("midrst_no_partial", N'(out_valid), '0);
        end
        @(posedge clk);
        #1;
        expQ.delete();
        runSingle("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        // Random throttling on both sides against the reference model.
        // A pending beat is held unchanged until it is accepted.
        accCount = 0;
        cycCount = 0;
        pend     = 1'b0;
        ra       = '0;
        rb       = '0;
        rc       = 1'b0;
        rs       = 1'b0;
        while (accCount < 10000 && cycCount < 60000) begin
            if (!pend) begin
                ra   = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : N'($urandom);
                rb   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : N'($urandom);
                rc   = 1'($urandom_range(0, 1));
                rs   = 1'($urandom_range(0, 1));
                pend = ($urandom_range(0, 3) != 0);
            end
            runCycle(pend, ra, rb, rc, rs, 1'($urandom_range(0, 3) != 0), got, rdy);
            if (got) begin
                pend = 1'b0;
                accCount++;
            end
            cycCount++;
        end
        checkOutput("random_beats", N'(accCount), N'(10000));
        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            runCycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, got, rdy);
        end
        checkOutput("random_drained", N'(expQ.size()), '0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
